// File: rtl/usxgmii_pkg.sv
// Shared types, lane characters and word constants for the XGMII to USXGMII
// transmit converter.
package usxgmii_pkg;

    typedef enum logic [2:0] {
        SPEED_10G  = 3'd0,
        SPEED_5G   = 3'd1,
        SPEED_2G5  = 3'd2,
        SPEED_1G   = 3'd3,
        SPEED_100M = 3'd4,
        SPEED_10M  = 3'd5
    } speed_e;

    localparam int REP_WIDTH = 10;

    localparam logic [7:0] CHAR_IDLE  = 8'h07;
    localparam logic [7:0] CHAR_START = 8'hFB;
    localparam logic [7:0] CHAR_TERM  = 8'hFD;
    localparam logic [7:0] CHAR_ERROR = 8'hFE;

    localparam logic [63:0] IDLE_DATA  = {8{CHAR_IDLE}};
    localparam logic [63:0] ERROR_DATA = {8{CHAR_ERROR}};
    localparam logic [7:0]  ALL_CTRL   = 8'hFF;

    // Number of times each 32-bit half is repeated at a given port speed.
    function automatic logic [REP_WIDTH-1:0] rep_factor(input speed_e speed);
        case (speed)
            SPEED_5G:   return 10'd2;
            SPEED_2G5:  return 10'd4;
            SPEED_1G:   return 10'd10;
            SPEED_100M: return 10'd100;
            SPEED_10M:  return 10'd1000;
            default:    return 10'd1;
        endcase
    endfunction

    // Reserved speed codes fall back to 10G.
    function automatic speed_e decode_speed(input logic [2:0] raw);
        case (raw)
            3'd1:    return SPEED_5G;
            3'd2:    return SPEED_2G5;
            3'd3:    return SPEED_1G;
            3'd4:    return SPEED_100M;
            3'd5:    return SPEED_10M;
            default: return SPEED_10G;
        endcase
    endfunction

endpackage

// File: rtl/xgmii_tx_skid_fifo.sv
// Two-entry input buffer. not_full is registered so the upstream ready never
// has a combinational path from the output side.
module xgmii_tx_skid_fifo #(
    parameter int p_width = 72
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [p_width-1:0] push_data,
    input  logic               pop,
    output logic [p_width-1:0] pop_data,
    output logic               empty,
    output logic               not_full
);

    logic [p_width-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic [1:0]         count_next;
    logic               not_full_q;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok  = push && not_full_q;
    assign pop_ok   = pop && (count != 2'd0);
    assign pop_data = mem[rd_ptr];
    assign empty    = (count == 2'd0);
    assign not_full = not_full_q;

    // Occupancy after this cycle's push/pop; both may happen together.
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            not_full_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count      <= count_next;
            not_full_q <= (count_next != 2'd2);
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/xgmii_to_usxgmii_convert.sv
// Converts 64-bit XGMII transmit words into 32-bit USXGMII words, replicating
// each half per the active port speed and filling underruns with IDLE/ERROR.
module xgmii_to_usxgmii_convert
    import usxgmii_pkg::*;
#(
    parameter int p_underrun_count_width = 16
) (
    input  logic                              i_usxgmii_clock,
    input  logic                              i_usxgmii_reset_n,
    input  logic [2:0]                        i_speed,
    input  logic                              i_xgmii_valid,
    output logic                              o_xgmii_ready,
    input  logic [7:0]                        i_xgmii_control,
    input  logic [63:0]                       i_xgmii_data,
    input  logic                              i_usxgmii_ready,
    output logic                              o_usxgmii_valid,
    output logic [3:0]                        o_usxgmii_control,
    output logic [31:0]                       o_usxgmii_data,
    output logic                              o_in_frame,
    output logic [p_underrun_count_width-1:0] o_underrun_count
);

    logic [71:0]                       fifo_data;
    logic                              fifo_empty;
    logic                              fifo_pop;

    logic [63:0]                       hold_data;
    logic [7:0]                        hold_ctrl;
    logic                              half_q;
    logic [REP_WIDTH-1:0]              rep_cnt;
    speed_e                            speed_q;
    logic                              in_frame_q;
    logic                              valid_q;
    logic [p_underrun_count_width-1:0] under_q;

    logic                              consume;
    logic                              rep_last;
    logic                              boundary;
    logic [63:0]                       load_data;
    logic [7:0]                        load_ctrl;
    logic                              next_frame;
    logic                              under_inc;

    xgmii_tx_skid_fifo #(
        .p_width(72)
    ) u_fifo (
        .clk      (i_usxgmii_clock),
        .rst_n    (i_usxgmii_reset_n),
        .push     (i_xgmii_valid),
        .push_data({i_xgmii_control, i_xgmii_data}),
        .pop      (fifo_pop),
        .pop_data (fifo_data),
        .empty    (fifo_empty),
        .not_full (o_xgmii_ready)
    );

    assign consume  = valid_q && i_usxgmii_ready;
    assign rep_last = (rep_cnt == rep_factor(speed_q) - 10'd1);
    assign boundary = consume && rep_last && half_q;
    assign fifo_pop = boundary && !fifo_empty;

    assign o_usxgmii_valid   = valid_q;
    assign o_usxgmii_data    = half_q ? hold_data[63:32] : hold_data[31:0];
    assign o_usxgmii_control = half_q ? hold_ctrl[7:4]   : hold_ctrl[3:0];
    assign o_in_frame        = in_frame_q;
    assign o_underrun_count  = under_q;

    // Choose the next held word and the framing state it leaves behind;
    // lanes are scanned in order so a Start after a Terminate wins.
    always_comb begin
        load_data  = IDLE_DATA;
        load_ctrl  = ALL_CTRL;
        next_frame = in_frame_q;
        under_inc  = 1'b0;
        if (!fifo_empty) begin
            load_data = fifo_data[63:0];
            load_ctrl = fifo_data[71:64];
            for (int i = 0; i < 8; i++) begin
                if ((i == 0 || i == 4) && fifo_data[64+i] &&
                    fifo_data[8*i +: 8] == CHAR_START) begin
                    next_frame = 1'b1;
                end else if (fifo_data[64+i] && fifo_data[8*i +: 8] == CHAR_TERM) begin
                    next_frame = 1'b0;
                end
            end
        end else if (in_frame_q) begin
            load_data = ERROR_DATA;
            under_inc = 1'b1;
        end
    end

    // Replication/half sequencing, holding register reload and speed latch.
    always_ff @(posedge i_usxgmii_clock or negedge i_usxgmii_reset_n) begin
        if (!i_usxgmii_reset_n) begin
            valid_q    <= 1'b0;
            hold_data  <= IDLE_DATA;
            hold_ctrl  <= ALL_CTRL;
            half_q     <= 1'b0;
            rep_cnt    <= '0;
            speed_q    <= SPEED_10G;
            in_frame_q <= 1'b0;
            under_q    <= '0;
        end else begin
            valid_q <= 1'b1;
            if (consume) begin
                if (rep_last) begin
                    rep_cnt <= '0;
                    half_q  <= ~half_q;
                end else begin
                    rep_cnt <= rep_cnt + 10'd1;
                end
            end
            if (boundary) begin
                hold_data  <= load_data;
                hold_ctrl  <= load_ctrl;
                in_frame_q <= next_frame;
                if (under_inc && under_q != {p_underrun_count_width{1'b1}}) begin
                    under_q <= under_q + 1'b1;
                end
                // Speed changes only take effect between frames.
                if (!next_frame) begin
                    speed_q <= decode_speed(i_speed);
                end
            end
        end
    end

endmodule

// File: tb/tb_xgmii_to_usxgmii_convert.sv
// Bench for the XGMII to USXGMII transmit converter: directed vectors, corner
// sequences and randomized traffic against a word-level reference model.
module tb_xgmii_to_usxgmii_convert;

    localparam int UW = 3;
    localparam int UMAX = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    speed;
    logic          xv;
    logic          xr;
    logic [7:0]    xc;
    logic [63:0]   xd;
    logic          pr;
    logic          uv;
    logic [3:0]    uc;
    logic [31:0]   ud;
    logic          inf;
    logic [UW-1:0] ucnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xgmii_to_usxgmii_convert #(
        .p_underrun_count_width(UW)
    ) dut (
        .i_usxgmii_clock  (clk),
        .i_usxgmii_reset_n(rst_n),
        .i_speed          (speed),
        .i_xgmii_valid    (xv),
        .o_xgmii_ready    (xr),
        .i_xgmii_control  (xc),
        .i_xgmii_data     (xd),
        .i_usxgmii_ready  (pr),
        .o_usxgmii_valid  (uv),
        .o_usxgmii_control(uc),
        .o_usxgmii_data   (ud),
        .o_in_frame       (inf),
        .o_underrun_count (ucnt)
    );

    // ---------------- reference model (word level) ----------------
    logic [71:0] mq[$];
    logic [63:0] m_data;
    logic [7:0]  m_ctrl;
    int          m_half, m_rep, m_speed, m_under;
    bit          m_frame, m_valid, m_ready;

    function automatic int rep_of(input int s);
        int t[6];
        t = '{1, 2, 4, 10, 100, 1000};
        return t[s];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_data = 64'h0707070707070707; m_ctrl = 8'hFF;
        m_half = 0; m_rep = 0; m_speed = 0; m_under = 0;
        m_frame = 0; m_valid = 0; m_ready = 0;
    endtask

    task automatic model_boundary(input logic [2:0] sp);
        logic [71:0] w;
        if (mq.size() > 0) begin
            w = mq.pop_front();
            m_data = w[63:0];
            m_ctrl = w[71:64];
            for (int l = 0; l < 8; l++) begin
                if ((l == 0 || l == 4) && m_ctrl[l] && m_data[8*l +: 8] == 8'hFB) m_frame = 1;
                if (m_ctrl[l] && m_data[8*l +: 8] == 8'hFD) m_frame = 0;
            end
        end else if (m_frame) begin
            m_data = 64'hFEFEFEFEFEFEFEFE; m_ctrl = 8'hFF;
            if (m_under < UMAX) m_under++;
        end else begin
            m_data = 64'h0707070707070707; m_ctrl = 8'hFF;
        end
        if (!m_frame) m_speed = (sp > 3'd5) ? 0 : int'(sp);
    endtask

    task automatic model_step(input bit v, input logic [7:0] c, input logic [63:0] d,
                              input bit p, input logic [2:0] sp, output bit acc);
        acc = v && m_ready;
        if (m_valid && p) begin
            m_rep++;
            if (m_rep == rep_of(m_speed)) begin
                m_rep = 0;
                if (m_half == 0) m_half = 1;
                else begin
                    m_half = 0;
                    model_boundary(sp);
                end
            end
        end
        if (acc) mq.push_back({c, d});
        m_valid = 1;
        m_ready = (mq.size() < 2);
    endtask

    task automatic model_check();
        logic [31:0] ed;
        logic [3:0]  ec;
        ed = m_half ? m_data[63:32] : m_data[31:0];
        ec = m_half ? m_ctrl[7:4] : m_ctrl[3:0];
        n_tests++;
        if (uv !== m_valid || xr !== m_ready || ud !== ed || uc !== ec ||
            inf !== m_frame || ucnt !== UW'(m_under)) begin
            n_fail++;
            $display("FAIL model t=%0t: got v=%b rdy=%b d=%h c=%h f=%b u=%0d required v=%b rdy=%b d=%h c=%h f=%b u=%0d",
                     $time, uv, xr, ud, uc, inf, ucnt, m_valid, m_ready, ed, ec, m_frame, m_under);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        model_check();
    endtask

    task automatic drive_step(input bit v, input logic [7:0] c, input logic [63:0] d,
                              input bit p, input logic [2:0] sp, output bit acc);
        xv = v; xc = c; xd = d; pr = p; speed = sp;
        model_step(v, c, d, p, sp, acc);
    endtask

    task automatic run_idle(input int n, input logic [2:0] sp);
        bit a;
        for (int i = 0; i < n; i++) begin
            tick_check();
            drive_step(0, 8'h00, 64'h0, 1, sp, a);
        end
    endtask

    task automatic push_one(input logic [7:0] c, input logic [63:0] d, input logic [2:0] sp);
        bit a;
        a = 0;
        for (int i = 0; i < 50 && !a; i++) begin
            tick_check();
            drive_step(1, c, d, 1, sp, a);
        end
        chk("push_accepted", a, 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          v;
        logic [7:0]  c;
        logic [63:0] d;
        logic [31:0] e_data;
        logic [3:0]  e_ctrl;
        bit          e_frame;
        int          e_under;
        bit          e_ready;
    } vec_t;

    vec_t tbl[9];

    initial begin
        bit          acc;
        logic [31:0] snap;
        logic [71:0] words[$];
        logic [31:0] got[$];
        logic [31:0] exp_seq[6];
        int          cnt_lo, cnt_hi, cnt_d1, cnt_d2, cnt_n;
        bit          go4;

        tbl[0] = '{1'b1, 8'h01, 64'hD5555555555555FB, 32'h07070707, 4'hF, 1'b0, 0, 1'b1};
        tbl[1] = '{1'b0, 8'h00, 64'h0,                32'h07070707, 4'hF, 1'b0, 0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 64'h0,                32'h555555FB, 4'h1, 1'b1, 0, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 64'h0,                32'hD5555555, 4'h0, 1'b1, 0, 1'b1};
        tbl[4] = '{1'b1, 8'hFF, 64'h07070707070707FD, 32'hFEFEFEFE, 4'hF, 1'b1, 1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 64'h0,                32'hFEFEFEFE, 4'hF, 1'b1, 1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 64'h0,                32'h070707FD, 4'hF, 1'b0, 1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 64'h0,                32'h07070707, 4'hF, 1'b0, 1, 1'b1};
        tbl[8] = '{1'b0, 8'h00, 64'h0,                32'h07070707, 4'hF, 1'b0, 1, 1'b1};

        // Reset
        rst_n = 0; xv = 0; xc = 0; xd = 0; pr = 1; speed = 0;
        repeat (5) @(negedge clk);
        chk("rst_valid", uv, 0);
        chk("rst_ready", xr, 0);
        chk("rst_data", ud, 32'h07070707);
        chk("rst_ctrl", uc, 4'hF);
        chk("rst_frame", inf, 0);
        chk("rst_under", ucnt, 0);
        rst_n = 1;
        model_reset();
        model_step(0, 8'h00, 64'h0, 1, 3'd0, acc);

        // 10G passthrough, underrun and terminate
        for (int k = 0; k < 9; k++) begin
            tick_check();
            chk($sformatf("vec%0d_data", k), ud, tbl[k].e_data);
            chk($sformatf("vec%0d_ctrl", k), uc, tbl[k].e_ctrl);
            chk($sformatf("vec%0d_frame", k), inf, tbl[k].e_frame);
            chk($sformatf("vec%0d_under", k), ucnt, UW'(tbl[k].e_under));
            chk($sformatf("vec%0d_ready", k), xr, tbl[k].e_ready);
            drive_step(tbl[k].v, tbl[k].c, tbl[k].d, 1, 3'd0, acc);
        end

        // 1G replication
        run_idle(4, 3'd3);
        push_one(8'h00, 64'h22222222_11111111, 3'd3);
        cnt_lo = 0; cnt_hi = 0;
        for (int i = 0; i < 120; i++) begin
            tick_check();
            if (ud == 32'h11111111) cnt_lo++;
            if (ud == 32'h22222222) cnt_hi++;
            drive_step(0, 8'h00, 64'h0, 1, 3'd3, acc);
        end
        chk("rep1g_lower", cnt_lo, 10);
        chk("rep1g_upper", cnt_hi, 10);
        run_idle(30, 3'd0);

        // Backpressure with three words
        words = '{{8'h00, 64'hA1A1A1A1_A0A0A0A0},
                  {8'h00, 64'hB1B1B1B1_B0B0B0B0},
                  {8'h00, 64'hC1C1C1C1_C0C0C0C0}};
        exp_seq = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hB0B0B0B0,
                    32'hB1B1B1B1, 32'hC0C0C0C0, 32'hC1C1C1C1};
        snap = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick_check();
            if (i == 0) snap = ud;
            else chk("bp_stable", ud, snap);
            if (i == 2) chk("bp_ready_low", xr, 0);
            if (words.size() > 0) drive_step(1, words[0][71:64], words[0][63:0], 0, 3'd0, acc);
            else drive_step(0, 8'h00, 64'h0, 0, 3'd0, acc);
            if (acc) void'(words.pop_front());
        end
        for (int i = 0; i < 30; i++) begin
            tick_check();
            if (ud != 32'h07070707) got.push_back(ud);
            if (words.size() > 0) drive_step(1, words[0][71:64], words[0][63:0], 1, 3'd0, acc);
            else drive_step(0, 8'h00, 64'h0, 1, 3'd0, acc);
            if (acc) void'(words.pop_front());
        end
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) chk($sformatf("bp_order%0d", i), got[i], exp_seq[i]);
        end

        // Deferred speed change inside a frame
        words = '{{8'h01, 64'h33333333_444444FB},
                  {8'h00, 64'h55555555_66666666},
                  {8'h00, 64'h77777777_88888888},
                  {8'hFF, 64'h07070707070707FD},
                  {8'h00, 64'h99999999_AAAAAAAA}};
        go4 = 0; cnt_d1 = 0; cnt_d2 = 0; cnt_n = 0;
        for (int i = 0; i < 500; i++) begin
            tick_check();
            if (ud == 32'h66666666) cnt_d1++;
            if (ud == 32'h88888888) cnt_d2++;
            if (ud == 32'hAAAAAAAA) cnt_n++;
            if (words.size() > 0)
                drive_step(1, words[0][71:64], words[0][63:0], 1, go4 ? 3'd4 : 3'd0, acc);
            else
                drive_step(0, 8'h00, 64'h0, 1, go4 ? 3'd4 : 3'd0, acc);
            if (acc) void'(words.pop_front());
            if (m_frame) go4 = 1;
        end
        chk("defer_d1_r1", cnt_d1, 1);
        chk("defer_d2_r1", cnt_d2, 1);
        chk("defer_next_r100", cnt_n, 100);
        chk("defer_frame_end", inf, 0);
        run_idle(220, 3'd0);

        // Underrun counter saturation
        push_one(8'h01, 64'hD5555555555555FB, 3'd0);
        run_idle(30, 3'd0);
        chk("sat_under", ucnt, UMAX);
        chk("sat_frame", inf, 1);
        push_one(8'hFF, 64'h07070707070707FD, 3'd0);
        run_idle(6, 3'd0);
        chk("sat_frame_end", inf, 0);
        chk("sat_hold", ucnt, UMAX);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] d;
            logic [7:0]  c;
            logic [2:0]  sp;
            int          r, lane;
            tick_check();
            sp = speed;
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 5))
                    0: sp = 3'd0;
                    1: sp = 3'd1;
                    2: sp = 3'd2;
                    3: sp = 3'd6;
                    4: sp = 3'd7;
                    default: sp = 3'd3;
                endcase
            end
            d = {$urandom, $urandom};
            c = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0) begin d[7:0] = 8'hFB; c[0] = 1'b1; end
            if (r == 1) begin d[39:32] = 8'hFB; c[4] = 1'b1; end
            if (r == 2 || r == 3) begin
                lane = $urandom_range(0, 7);
                d[8*lane +: 8] = 8'hFD;
                c[lane] = 1'b1;
            end
            drive_step(bit'($urandom_range(0, 1)), c, d, ($urandom_range(0, 3) != 0), sp, acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
